fetch_unit: RTL and testbench

Fetch stage that sits directly upstream of the instruction memory. It owns the program counter and drives `pc_address` to the memory. It tracks the one-cycle registered read latency of that memory and buffers returned instructions in a 2-entry skid FIFO. It hands the buffered instructions to decode with a valid/ready handshake, and supports redirects (branch/jump/trap) that flush wrong-path work.

---
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, tracks the one-cycle instruction memory latency and
// buffers returned words in a 2-entry skid FIFO. Optional macro FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_address,
    input  logic [31:0] instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc,
    output logic        if_fault
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } entry_t;

    entry_t [1:0] entry_q, entry_d;
    logic [1:0]   count_q, count_d;
    logic [31:0]  fetchPc_q, fetchPc_d;
    logic         inflight_q, inflight_d;
    logic [31:0]  inflightPc_q, inflightPc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic         halted_q, halted_d;
    logic         faultPending_q, faultPending_d;
`endif

    logic         pop;
    logic         issue;
    logic         push;
    logic [2:0]   occupancy;
    entry_t       pushEntry;

    // Issue only when the FIFO can still absorb everything already in flight.
    always_comb begin
        pop       = (count_q != 2'd0) & id_ready & ~redirect_valid;
        occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue     = ~redirect_valid & (occupancy < 3'd2);
        push      = ~redirect_valid & inflight_q;
        pushEntry = '{pc: inflightPc_q, instr: instruction, fault: 1'b0};
`ifdef FETCH_MISALIGN_TRAP_EN
        issue     = issue & ~halted_q;
        if (faultPending_q) begin
            push      = ~redirect_valid;
            pushEntry = '{pc: fetchPc_q, instr: 32'h0000_0000, fault: 1'b1};
        end
`endif
    end

    always_comb begin
        fetchPc_d    = fetchPc_q;
        inflight_d   = issue;
        inflightPc_d = issue ? fetchPc_q : inflightPc_q;
        entry_d      = entry_q;
        count_d      = count_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        halted_d       = halted_q;
        faultPending_d = 1'b0;
`endif
        if (redirect_valid) begin
            inflight_d = 1'b0;
            count_d    = 2'd0;
            entry_d    = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fetchPc_d      = redirect_target;
            halted_d       = |redirect_target[1:0];
            faultPending_d = |redirect_target[1:0];
`else
            fetchPc_d      = redirect_target & 32'hFFFF_FFFC;
`endif
        end else begin
            if (issue) begin
                fetchPc_d = fetchPc_q + 32'd4;
            end
            // Slot 0 is always the head; a vacated slot is zeroed so empty reads 0.
            case ({push, pop})
                2'b01: begin
                    entry_d[0] = entry_q[1];
                    entry_d[1] = '0;
                    count_d    = count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        entry_d[0] = pushEntry;
                    end else begin
                        entry_d[1] = pushEntry;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        entry_d[0] = pushEntry;
                    end else begin
                        entry_d[0] = entry_q[1];
                        entry_d[1] = pushEntry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetchPc_q    <= RESET_PC;
            inflight_q   <= 1'b0;
            inflightPc_q <= 32'h0000_0000;
            entry_q      <= '0;
            count_q      <= 2'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
            halted_q       <= 1'b0;
            faultPending_q <= 1'b0;
`endif
        end else begin
            fetchPc_q    <= fetchPc_d;
            inflight_q   <= inflight_d;
            inflightPc_q <= inflightPc_d;
            entry_q      <= entry_d;
            count_q      <= count_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            halted_q       <= halted_d;
            faultPending_q <= faultPending_d;
`endif
        end
    end

    assign pc_address     = fetchPc_q;
    assign if_valid       = (count_q != 2'd0);
    assign if_instruction = entry_q[0].instr;
    assign if_pc          = entry_q[0].pc;
    assign if_fault       = entry_q[0].fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, redirect, misaligned redirect,
// mid-stream reset, plus a second instance started near the top of the address space.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pcAddress;
    logic [31:0] instruction = 32'h0;
    logic        redirectValid;
    logic [31:0] redirectTarget;
    logic        ifValid;
    logic        idReady;
    logic [31:0] ifInstruction;
    logic [31:0] ifPc;
    logic        ifFault;

    logic [31:0] wPcAddress;
    logic [31:0] wInstruction = 32'h0;
    logic        wRedirectValid = 1'b0;
    logic [31:0] wRedirectTarget = 32'h0;
    logic        wIfValid;
    logic        wIdReady = 1'b1;
    logic [31:0] wIfInstruction;
    logic [31:0] wIfPc;
    logic        wIfFault;

    int          testsRun = 0;
    int          testsFailed = 0;
    int          cyc = 0;
    logic [31:0] expPc;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .pc_address      (pcAddress),
        .instruction     (instruction),
        .redirect_valid  (redirectValid),
        .redirect_target (redirectTarget),
        .if_valid        (ifValid),
        .id_ready        (idReady),
        .if_instruction  (ifInstruction),
        .if_pc           (ifPc),
        .if_fault        (ifFault)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dutWrap (
        .clk             (clk),
        .reset           (reset),
        .pc_address      (wPcAddress),
        .instruction     (wInstruction),
        .redirect_valid  (wRedirectValid),
        .redirect_target (wRedirectTarget),
        .if_valid        (wIfValid),
        .id_ready        (wIdReady),
        .if_instruction  (wIfInstruction),
        .if_pc           (wIfPc),
        .if_fault        (wIfFault)
    );

    // Registered instruction memory: word k holds 0x1000_0000 + k.
    always @(posedge clk) begin
        instruction  <= 32'h1000_0000 + {2'b00, pcAddress[31:2]};
        wInstruction <= 32'h1000_0000 + {2'b00, wPcAddress[31:2]};
    end

    // The FIFO must never be written while full.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(dut.push && dut.count_q == 2'd2)) else begin
                testsFailed++;
                $error("[TB] FAIL overflow: push observed with count %0d, required count < 2", dut.count_q);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic [31:0] tgt, input logic rdy);
        redirectValid  = rv;
        redirectTarget = tgt;
        idReady        = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;

        checkOutput("reset_valid", {31'b0, ifValid}, 32'd0);
        checkOutput("reset_pc", ifPc, 32'h0);
        checkOutput("reset_instr", ifInstruction, 32'h0);
        checkOutput("reset_fault", {31'b0, ifFault}, 32'd0);
        checkOutput("reset_addr", pcAddress, 32'h0);
        checkOutput("wrap_reset_addr", wPcAddress, 32'hFFFF_FFF8);
        step();
        checkOutput("c1_valid", {31'b0, ifValid}, 32'd0);
        checkOutput("c1_addr", pcAddress, 32'h4);
        step();

        for (int k = 2; k < 6; k++) begin
            checkOutput("stream_valid", {31'b0, ifValid}, 32'd1);
            checkOutput("stream_pc", ifPc, 32'(4 * (k - 2)));
            checkOutput("stream_instr", ifInstruction, 32'h1000_0000 + 32'(k - 2));
            checkOutput("stream_addr", pcAddress, 32'(4 * k));
            if (k <= 4) begin
                expPc = 32'hFFFF_FFF8 + 32'(4 * (k - 2));
                checkOutput("wrap_valid", {31'b0, wIfValid}, 32'd1);
                checkOutput("wrap_pc", wIfPc, expPc);
                checkOutput("wrap_instr", wIfInstruction, 32'h1000_0000 + (expPc >> 2));
            end
            step();
        end

        // Cycle 6: head is pc 0x10; decode stalls for five cycles.
        applyStimulus(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_valid", {31'b0, ifValid}, 32'd1);
            checkOutput("stall_pc", ifPc, 32'h10);
            checkOutput("stall_instr", ifInstruction, 32'h1000_0004);
            checkOutput("stall_addr", pcAddress, 32'h18);
            step();
        end

        // Cycle 11: release; 0x10, 0x14, 0x18, 0x1C follow back to back.
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("release_pc0", ifPc, 32'h10);
        step();
        checkOutput("release_pc1", ifPc, 32'h14);
        checkOutput("release_addr", pcAddress, 32'h1C);
        step();
        checkOutput("release_pc2", ifPc, 32'h18);
        step();
        checkOutput("release_pc3", ifPc, 32'h1C);
        checkOutput("release_instr3", ifInstruction, 32'h1000_0007);
        step();

        // Cycle 15: stall again to fill both FIFO slots, then redirect with id_ready high.
        checkOutput("prefill_pc", ifPc, 32'h20);
        applyStimulus(1'b0, 32'h0, 1'b0);
        step();
        checkOutput("full_valid", {31'b0, ifValid}, 32'd1);
        checkOutput("full_pc", ifPc, 32'h20);
        checkOutput("full_addr", pcAddress, 32'h28);
        applyStimulus(1'b1, 32'h200, 1'b1);
        step();
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("redir_r1_valid", {31'b0, ifValid}, 32'd0);
        checkOutput("redir_r1_addr", pcAddress, 32'h200);
        step();
        checkOutput("redir_r2_valid", {31'b0, ifValid}, 32'd0);
        checkOutput("redir_r2_pc", ifPc, 32'h0);
        step();
        checkOutput("redir_r3_valid", {31'b0, ifValid}, 32'd1);
        checkOutput("redir_r3_pc", ifPc, 32'h200);
        checkOutput("redir_r3_instr", ifInstruction, 32'h1000_0080);
        checkOutput("redir_r3_fault", {31'b0, ifFault}, 32'd0);
        step();
        checkOutput("redir_r4_pc", ifPc, 32'h204);
        step();
        checkOutput("redir_r5_pc", ifPc, 32'h208);

        // Cycle 21: redirect to a misaligned target.
        applyStimulus(1'b1, 32'h202, 1'b1);
        step();
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("mis_r1_valid", {31'b0, ifValid}, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        checkOutput("mis_r1_addr", pcAddress, 32'h202);
        step();
        checkOutput("mis_r2_valid", {31'b0, ifValid}, 32'd1);
        checkOutput("mis_r2_fault", {31'b0, ifFault}, 32'd1);
        checkOutput("mis_r2_pc", ifPc, 32'h202);
        checkOutput("mis_r2_instr", ifInstruction, 32'h0);
        step();
        checkOutput("mis_r3_valid", {31'b0, ifValid}, 32'd0);
        step();
        checkOutput("mis_r4_valid", {31'b0, ifValid}, 32'd0);
        checkOutput("mis_r4_addr", pcAddress, 32'h202);
`else
        checkOutput("mis_r1_addr", pcAddress, 32'h200);
        step();
        checkOutput("mis_r2_valid", {31'b0, ifValid}, 32'd0);
        step();
        checkOutput("mis_r3_valid", {31'b0, ifValid}, 32'd1);
        checkOutput("mis_r3_pc", ifPc, 32'h200);
        checkOutput("mis_r3_fault", {31'b0, ifFault}, 32'd0);
`endif

        // Mid-stream reset: everything returns to its reset state and restarts.
        reset = 1'b1;
        step();
        checkOutput("mreset_valid", {31'b0, ifValid}, 32'd0);
        checkOutput("mreset_pc", ifPc, 32'h0);
        checkOutput("mreset_instr", ifInstruction, 32'h0);
        checkOutput("mreset_addr", pcAddress, 32'h0);
        reset = 1'b0;
        cyc   = 0;
        step();
        checkOutput("mreset_c1_valid", {31'b0, ifValid}, 32'd0);
        step();
        checkOutput("mreset_c2_valid", {31'b0, ifValid}, 32'd1);
        checkOutput("mreset_c2_pc", ifPc, 32'h0);
        checkOutput("mreset_c2_instr", ifInstruction, 32'h1000_0000);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
